// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: occupancy states and default widths.
package pipe_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int CTRL_W_DEF = 3;
    localparam int ADDR_W_DEF = 5;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;
endpackage

// File: rtl/pipe_skid_slot.sv
// One holding slot: valid flag, payload and control bits, with load and clear.
// Clear only drops valid and control; the payload keeps its last value.
module pipe_skid_slot
    import pipe_pkg::*;
#(
    parameter int PAY_W  = DATA_W_DEF + ADDR_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [PAY_W-1:0]  d_pay,
    input  logic [CTRL_W-1:0] d_ctrl,
    output logic              vld,
    output logic [PAY_W-1:0]  pay,
    output logic [CTRL_W-1:0] ctrl
);
    logic              vld_d,  vld_q;
    logic [PAY_W-1:0]  pay_d,  pay_q;
    logic [CTRL_W-1:0] ctrl_d, ctrl_q;

    always_comb begin
        vld_d  = vld_q;
        pay_d  = pay_q;
        ctrl_d = ctrl_q;
        if (clear) begin
            vld_d  = 1'b0;
            ctrl_d = '0;
        end else if (load) begin
            vld_d  = 1'b1;
            pay_d  = d_pay;
            ctrl_d = d_ctrl;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= 1'b0;
            pay_q  <= '0;
            ctrl_q <= '0;
        end else begin
            vld_q  <= vld_d;
            pay_q  <= pay_d;
            ctrl_q <= ctrl_d;
        end
    end

    assign vld  = vld_q;
    assign pay  = pay_q;
    assign ctrl = ctrl_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with optional two-entry skid buffer and flush.
// With SKID=1 in_ready is registered; with SKID=0 it is combinational from out_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [ADDR_W-1:0] out_rd
);
    localparam int PAY_W = DATA_W + ADDR_W;

    pipe_state_t       state_d, state_q;
    logic              in_ready_d, in_ready_q;
    logic              accept, drain;
    logic              main_load, main_clear, main_from_skid;
    logic              skid_load, skid_clear;
    logic              main_vld, skid_vld;
    logic [PAY_W-1:0]  main_pay_d, main_pay, skid_pay;
    logic [CTRL_W-1:0] main_ctrl_d, main_ctrl, skid_ctrl;

    assign in_ready = (SKID != 0) ? in_ready_q : (!main_vld || out_ready);
    assign accept   = in_valid && in_ready;
    assign drain    = main_vld && out_ready;

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_clear     = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    main_load = 1'b1;
                    state_d   = ONE;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    main_load = 1'b1;
                end else if (accept && (SKID != 0)) begin
                    skid_load = 1'b1;
                    state_d   = FULL;
                end else if (drain) begin
                    main_clear = 1'b1;
                    state_d    = EMPTY;
                end
            end
            FULL: begin
                // Skid beat is older than anything upstream, so it refills main first.
                if (drain) begin
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                    skid_clear     = 1'b1;
                    state_d        = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            main_load  = 1'b0;
            skid_load  = 1'b0;
            main_clear = 1'b1;
            skid_clear = 1'b1;
            state_d    = EMPTY;
        end
        in_ready_d  = (state_d != FULL);
        main_pay_d  = main_from_skid ? skid_pay  : {in_data, in_rd};
        main_ctrl_d = main_from_skid ? skid_ctrl : in_ctrl;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    pipe_skid_slot #(.PAY_W(PAY_W), .CTRL_W(CTRL_W)) u_main (
        .clk    (clk),
        .rst    (rst),
        .load   (main_load),
        .clear  (main_clear),
        .d_pay  (main_pay_d),
        .d_ctrl (main_ctrl_d),
        .vld    (main_vld),
        .pay    (main_pay),
        .ctrl   (main_ctrl)
    );

    pipe_skid_slot #(.PAY_W(PAY_W), .CTRL_W(CTRL_W)) u_skid (
        .clk    (clk),
        .rst    (rst),
        .load   (skid_load),
        .clear  (skid_clear),
        .d_pay  ({in_data, in_rd}),
        .d_ctrl (in_ctrl),
        .vld    (skid_vld),
        .pay    (skid_pay),
        .ctrl   (skid_ctrl)
    );

    assign out_valid          = main_vld;
    assign {out_data, out_rd} = main_pay;
    assign out_ctrl           = main_ctrl;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: SKID=1 and SKID=0 instances share stimulus and are
// each compared against a FIFO-occupancy reference queue.
module tb_pipe_stage_reg;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic [2:0]  in_ctrl = '0;
    logic [4:0]  in_rd = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready1, out_valid1, in_ready0, out_valid0;
    logic [31:0] out_data1, out_data0;
    logic [2:0]  out_ctrl1, out_ctrl0;
    logic [4:0]  out_rd1, out_rd0;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [31:0] d;
        logic [2:0]  c;
        logic [4:0]  rd;
    } beat_t;
    beat_t m1[$];
    beat_t m0[$];

    typedef struct {
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        fl;
        logic        ov;
        logic [31:0] od;
        logic        ir;
    } vec_t;
    vec_t tbl[13];

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(3), .ADDR_W(5), .SKID(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .in_ctrl(in_ctrl), .in_rd(in_rd), .flush(flush),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .out_ctrl(out_ctrl1), .out_rd(out_rd1)
    );

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(3), .ADDR_W(5), .SKID(0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .in_ctrl(in_ctrl), .in_rd(in_rd), .flush(flush),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
        .out_ctrl(out_ctrl0), .out_rd(out_rd0)
    );

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic iv, input logic [31:0] d, input logic [2:0] c,
                         input logic ordy, input logic fl);
        in_valid  = iv;
        in_data   = d;
        in_ctrl   = c;
        in_rd     = d[4:0];
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic update_models();
        beat_t b;
        logic  r1, r0;
        b = '{d: in_data, c: in_ctrl, rd: in_rd};
        r1 = (m1.size() < 2);
        r0 = (m0.size() == 0) || out_ready;
        if (flush) begin
            m1.delete();
            m0.delete();
        end else begin
            if (m1.size() > 0 && out_ready) void'(m1.pop_front());
            if (in_valid && r1) m1.push_back(b);
            if (m0.size() > 0 && out_ready) void'(m0.pop_front());
            if (in_valid && r0) m0.push_back(b);
        end
    endtask

    task automatic check_models();
        cmp("s1_out_valid", out_valid1, m1.size() > 0);
        cmp("s1_in_ready", in_ready1, m1.size() < 2);
        if (m1.size() > 0) begin
            cmp("s1_out_data", out_data1, m1[0].d);
            cmp("s1_out_ctrl", out_ctrl1, m1[0].c);
            cmp("s1_out_rd", out_rd1, m1[0].rd);
        end else begin
            cmp("s1_bubble_ctrl", out_ctrl1, 0);
        end
        cmp("s0_out_valid", out_valid0, m0.size() > 0);
        if (m0.size() > 0) begin
            cmp("s0_out_data", out_data0, m0[0].d);
            cmp("s0_out_ctrl", out_ctrl0, m0[0].c);
            cmp("s0_out_rd", out_rd0, m0[0].rd);
        end else begin
            cmp("s0_bubble_ctrl", out_ctrl0, 0);
        end
    endtask

    // Inputs are driven on the falling edge; one call covers one rising edge.
    task automatic cycle();
        #1;
        cmp("s0_in_ready", in_ready0, (m0.size() == 0) || out_ready);
        update_models();
        @(posedge clk);
        @(negedge clk);
        check_models();
    endtask

    initial begin
        tbl[0]  = '{1'b1, 32'h1, 1'b1, 1'b0, 1'b1, 32'h1, 1'b1};
        tbl[1]  = '{1'b1, 32'h2, 1'b1, 1'b0, 1'b1, 32'h2, 1'b1};
        tbl[2]  = '{1'b1, 32'h3, 1'b1, 1'b0, 1'b1, 32'h3, 1'b1};
        tbl[3]  = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1};
        tbl[4]  = '{1'b1, 32'hA, 1'b0, 1'b0, 1'b1, 32'hA, 1'b1};
        tbl[5]  = '{1'b1, 32'hB, 1'b0, 1'b0, 1'b1, 32'hA, 1'b0};
        tbl[6]  = '{1'b1, 32'hD, 1'b0, 1'b0, 1'b1, 32'hA, 1'b0};
        tbl[7]  = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'hB, 1'b1};
        tbl[8]  = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1};
        tbl[9]  = '{1'b1, 32'hE, 1'b0, 1'b0, 1'b1, 32'hE, 1'b1};
        tbl[10] = '{1'b1, 32'hF, 1'b0, 1'b0, 1'b1, 32'hE, 1'b0};
        tbl[11] = '{1'b1, 32'hC, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1};
        tbl[12] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        cmp("rst_out_valid", out_valid1, 0);
        cmp("rst_in_ready", in_ready1, 1);
        cmp("rst_out_data", out_data1, 0);
        cmp("rst_out_ctrl", out_ctrl1, 0);
        cmp("rst_out_rd", out_rd1, 0);
        cmp("rst_s0_out_valid", out_valid0, 0);
        rst = 1'b0;

        // Streaming, backpressure and flush vectors on the skid instance
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].iv, tbl[i].d, 3'b101, tbl[i].ordy, tbl[i].fl);
            cycle();
            cmp($sformatf("vec%0d_out_valid", i), out_valid1, tbl[i].ov);
            cmp($sformatf("vec%0d_in_ready", i), in_ready1, tbl[i].ir);
            cmp($sformatf("vec%0d_out_ctrl", i), out_ctrl1, tbl[i].ov ? 3'b101 : 3'b000);
            if (tbl[i].ov) cmp($sformatf("vec%0d_out_data", i), out_data1, tbl[i].od);
        end

        // Asynchronous reset while holding a beat
        drive(1'b1, 32'h55, 3'b111, 1'b0, 1'b0);
        cycle();
        drive(1'b0, 32'h0, 3'b000, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        cmp("arst_out_valid", out_valid1, 0);
        cmp("arst_out_data", out_data1, 0);
        cmp("arst_out_ctrl", out_ctrl1, 0);
        cmp("arst_out_rd", out_rd1, 0);
        cmp("arst_in_ready", in_ready1, 1);
        cmp("arst_s0_out_valid", out_valid0, 0);
        m1.delete();
        m0.delete();
        @(negedge clk);
        rst = 1'b0;

        // Combinational ready on the single-register instance
        drive(1'b1, 32'h11, 3'b011, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 32'h22, 3'b001, 1'b0, 1'b0);
        #1;
        cmp("s0_stall_in_ready", in_ready0, 0);
        out_ready = 1'b1;
        #1;
        cmp("s0_pass_in_ready", in_ready0, 1);
        cycle();
        cmp("s0_replaced_data", out_data0, 32'h22);
        drive(1'b0, 32'h0, 3'b000, 1'b1, 1'b0);
        cycle();

        // Randomised traffic
        for (int n = 0; n < 10000; n++) begin
            drive(($urandom % 4) != 0, $urandom, 3'($urandom), ($urandom % 3) != 0,
                  ($urandom % 50) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
